spi_cfg_ctrl: RTL and testbench

Configuration controller between the config input pads (config_req, config_data[5:0]) and the SPI engine/output pads (cpol, cpha, spi_width[3:0]).
- Parses framed multi-beat commands from the pad interface into a shadow register.
- Transfers shadow to the active register only when the SPI engine is idle, with timeout.
- Reports completion and errors to the core.

---
 rtl/spi_cfg_pkg.sv | 39 +++
 rtl/spi_cfg_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_spi_cfg_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared encodings for the SPI configuration controller: commands, error codes, FSM states, config record.
package spi_cfg_pkg;

    typedef enum logic [1:0] {
        CMD_NOP     = 2'b00,
        CMD_WRITE   = 2'b01,
        CMD_COMMIT  = 2'b10,
        CMD_DEFAULT = 2'b11
    } cmd_e;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_KEY     = 3'd1;
    localparam logic [2:0] ERR_TRUNC   = 3'd2;
    localparam logic [2:0] ERR_OVERLEN = 3'd3;
    localparam logic [2:0] ERR_WIDTH   = 3'd4;
    localparam logic [2:0] ERR_CHECK   = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT = 3'd6;
    localparam logic [2:0] ERR_COLLIDE = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CHECK,
        S_END,
        S_APPLY,
        S_DRAIN
    } state_e;

    typedef struct packed {
        logic       cpol;
        logic       cpha;
        logic [3:0] width;
    } cfg_t;

    function automatic logic onehot4(input logic [3:0] w);
        return (w != 4'd0) && ((w & (w - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/spi_cfg_ctrl.sv
// Parses keyed multi-beat config frames into a shadow register and commits it to the
// active SPI settings only while the engine is idle, bounded by a timeout.
module spi_cfg_ctrl
    import spi_cfg_pkg::*;
#(
    parameter logic [3:0] KEY       = 4'hA,
    parameter logic       DEF_CPOL  = 1'b0,
    parameter logic       DEF_CPHA  = 1'b0,
    parameter logic [3:0] DEF_WIDTH = 4'b0001,
    parameter int         TIMEOUT   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       config_req,
    input  logic [5:0] config_data,
    input  logic       spi_busy,
    output logic       cpol,
    output logic       cpha,
    output logic [3:0] spi_width,
    output logic       cfg_pending,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [2:0] err_code
);

    localparam cfg_t        DEF_CFG  = '{cpol: DEF_CPOL, cpha: DEF_CPHA, width: DEF_WIDTH};
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    cmd_e        op_q;
    cfg_t        staged_q, shadow_q, active_q;
    logic [15:0] cnt_q;
    logic        collide_q;
    logic        pending_q, done_q, err_q;
    logic [2:0]  err_code_q;

    cmd_e       hdr_cmd;
    logic       key_ok;
    logic       err_set, err_clr, op_en, stage_en, shadow_wr;
    logic       do_commit, do_default, cnt_clr, cnt_inc;
    logic [2:0] err_val;

    assign hdr_cmd = cmd_e'(config_data[5:4]);
    assign key_ok  = (config_data[3:0] == KEY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_set    = 1'b0;
        err_val    = ERR_NONE;
        err_clr    = 1'b0;
        op_en      = 1'b0;
        stage_en   = 1'b0;
        shadow_wr  = 1'b0;
        do_commit  = 1'b0;
        do_default = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (config_req) begin
                    if (!key_ok) begin
                        err_set = 1'b1;
                        err_val = ERR_KEY;
                        state_d = S_DRAIN;
                    end else begin
                        err_clr = 1'b1;
                        op_en   = 1'b1;
                        state_d = (hdr_cmd == CMD_WRITE) ? S_PAYLOAD : S_END;
                    end
                end
            end
            S_PAYLOAD: begin
                if (!config_req) begin
                    err_set = 1'b1;
                    err_val = ERR_TRUNC;
                    state_d = S_IDLE;
                end else begin
                    stage_en = 1'b1;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!config_req) begin
                    err_set = 1'b1;
                    err_val = ERR_TRUNC;
                    state_d = S_IDLE;
                end else if (config_data != 6'(~staged_q)) begin
                    err_set = 1'b1;
                    err_val = ERR_CHECK;
                    state_d = S_DRAIN;
                end else if (!onehot4(staged_q.width)) begin
                    err_set = 1'b1;
                    err_val = ERR_WIDTH;
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_END;
                end
            end
            S_END: begin
                if (config_req) begin
                    err_set = 1'b1;
                    err_val = ERR_OVERLEN;
                    state_d = S_DRAIN;
                end else begin
                    case (op_q)
                        CMD_WRITE: begin
                            shadow_wr = 1'b1;
                            state_d   = S_IDLE;
                        end
                        CMD_NOP: state_d = S_IDLE;
                        default: begin
                            cnt_clr = 1'b1;
                            state_d = S_APPLY;
                        end
                    endcase
                end
            end
            S_APPLY: begin
                // A frame arriving mid-apply is flagged once; collide_q suppresses repeats.
                if (config_req && !collide_q) begin
                    err_set = 1'b1;
                    err_val = ERR_COLLIDE;
                end
                if (!spi_busy) begin
                    do_commit  = (op_q == CMD_COMMIT);
                    do_default = (op_q == CMD_DEFAULT);
                    state_d    = config_req ? S_DRAIN : S_IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    err_set = 1'b1;
                    err_val = ERR_TIMEOUT;
                    state_d = config_req ? S_DRAIN : S_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!config_req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= CMD_NOP;
            staged_q   <= DEF_CFG;
            shadow_q   <= DEF_CFG;
            active_q   <= DEF_CFG;
            cnt_q      <= 16'd0;
            collide_q  <= 1'b0;
            pending_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            done_q    <= do_commit | do_default;
            err_q     <= err_set;
            collide_q <= config_req && (state_d == S_APPLY);
            if (err_set) begin
                err_code_q <= err_val;
            end else if (err_clr) begin
                err_code_q <= ERR_NONE;
            end
            if (op_en) begin
                op_q <= hdr_cmd;
            end
            if (stage_en) begin
                staged_q <= cfg_t'(config_data);
            end
            if (shadow_wr) begin
                shadow_q  <= staged_q;
                pending_q <= 1'b1;
            end
            if (do_commit) begin
                active_q  <= shadow_q;
                pending_q <= 1'b0;
            end
            if (do_default) begin
                active_q  <= DEF_CFG;
                shadow_q  <= DEF_CFG;
                pending_q <= 1'b0;
            end
            if (cnt_clr) begin
                cnt_q <= 16'd0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign cpol        = active_q.cpol;
    assign cpha        = active_q.cpha;
    assign spi_width   = active_q.width;
    assign cfg_pending = pending_q;
    assign cfg_done    = done_q;
    assign cfg_err     = err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// Directed bench for spi_cfg_ctrl: a vector table of single-cycle expectations plus
// hand sequences for timeout, late busy release and resets mid-operation.
module tb_spi_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       config_req;
    logic [5:0] config_data;
    logic       spi_busy;
    logic       cpol, cpha;
    logic [3:0] spi_width;
    logic       cfg_pending, cfg_done, cfg_err;
    logic [2:0] err_code;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_cfg_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .config_req  (config_req),
        .config_data (config_data),
        .spi_busy    (spi_busy),
        .cpol        (cpol),
        .cpha        (cpha),
        .spi_width   (spi_width),
        .cfg_pending (cfg_pending),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .err_code    (err_code)
    );

    typedef struct {
        logic       r;
        logic       q;
        logic [5:0] d;
        logic       b;
        logic [5:0] act;
        logic       pend;
        logic       done;
        logic       err;
        logic [2:0] code;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic q, input logic [5:0] d, input logic b,
                       input logic [5:0] a, input logic p, input logic dn, input logic e,
                       input logic [2:0] c);
        vec_t t;
        t.r = r; t.q = q; t.d = d; t.b = b;
        t.act = a; t.pend = p; t.done = dn; t.err = e; t.code = c;
        vecs.push_back(t);
    endtask

    task automatic step(input logic r, input logic q, input logic [5:0] d, input logic b);
        @(negedge clk);
        rst         = r;
        config_req  = q;
        config_data = d;
        spi_busy    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [5:0] a, input logic p, input logic dn,
                       input logic e, input logic [2:0] c);
        logic [12:0] got, exp;
        got = {cpol, cpha, spi_width, cfg_pending, cfg_done, cfg_err, err_code};
        exp = {a, p, dn, e, c};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got act=%h pend=%b done=%b err=%b code=%0d, need act=%h pend=%b done=%b err=%b code=%0d",
                     nm, got[12:7], got[6], got[5], got[4], got[2:0], a, p, dn, e, c);
        end
    endtask

    task automatic wr(input logic [5:0] payload);
        step(0, 1, 6'h1A, 0);
        step(0, 1, payload, 0);
        step(0, 1, ~payload, 0);
        step(0, 0, 6'h00, 0);
    endtask

    initial begin
        rst = 1'b1; config_req = 1'b0; config_data = 6'h00; spi_busy = 1'b0;

        //   r  q  data   b   act    p  dn e  code
        add(1, 0, 6'h00, 0, 6'h01, 0, 0, 0, 3'd0);  // reset
        add(0, 1, 6'h1A, 0, 6'h01, 0, 0, 0, 3'd0);  // WRITE hdr
        add(0, 1, 6'h24, 0, 6'h01, 0, 0, 0, 3'd0);
        add(0, 1, 6'h1B, 0, 6'h01, 0, 0, 0, 3'd0);
        add(0, 0, 6'h00, 0, 6'h01, 1, 0, 0, 3'd0);  // shadow written
        add(0, 1, 6'h2A, 0, 6'h01, 1, 0, 0, 3'd0);  // COMMIT hdr
        add(0, 0, 6'h00, 0, 6'h01, 1, 0, 0, 3'd0);
        add(0, 0, 6'h00, 0, 6'h24, 0, 1, 0, 3'd0);  // applied N+2
        add(0, 0, 6'h00, 0, 6'h24, 0, 0, 0, 3'd0);
        add(0, 1, 6'h1A, 0, 6'h24, 0, 0, 0, 3'd0);  // WIDTH error frame
        add(0, 1, 6'h23, 0, 6'h24, 0, 0, 0, 3'd0);
        add(0, 1, 6'h1C, 0, 6'h24, 0, 0, 1, 3'd4);
        add(0, 0, 6'h00, 0, 6'h24, 0, 0, 0, 3'd4);
        add(0, 1, 6'h1A, 0, 6'h24, 0, 0, 0, 3'd0);  // TRUNC after payload
        add(0, 1, 6'h24, 0, 6'h24, 0, 0, 0, 3'd0);
        add(0, 0, 6'h00, 0, 6'h24, 0, 0, 1, 3'd2);
        add(0, 0, 6'h00, 0, 6'h24, 0, 0, 0, 3'd2);
        add(0, 1, 6'h15, 0, 6'h24, 0, 0, 1, 3'd1);  // bad key, 3 beats
        add(0, 1, 6'h15, 0, 6'h24, 0, 0, 0, 3'd1);
        add(0, 1, 6'h15, 0, 6'h24, 0, 0, 0, 3'd1);
        add(0, 0, 6'h00, 0, 6'h24, 0, 0, 0, 3'd1);
        add(0, 1, 6'h1A, 0, 6'h24, 0, 0, 0, 3'd0);  // next good frame
        add(0, 1, 6'h12, 0, 6'h24, 0, 0, 0, 3'd0);
        add(0, 1, 6'h2D, 0, 6'h24, 0, 0, 0, 3'd0);
        add(0, 0, 6'h00, 0, 6'h24, 1, 0, 0, 3'd0);
        add(0, 1, 6'h2A, 0, 6'h24, 1, 0, 0, 3'd0);  // COMMIT held 2 beats
        add(0, 1, 6'h2A, 0, 6'h24, 1, 0, 1, 3'd3);
        add(0, 0, 6'h00, 0, 6'h24, 1, 0, 0, 3'd3);
        add(0, 0, 6'h00, 0, 6'h24, 1, 0, 0, 3'd3);
        add(0, 1, 6'h2A, 0, 6'h24, 1, 0, 0, 3'd0);  // proper COMMIT
        add(0, 0, 6'h00, 0, 6'h24, 1, 0, 0, 3'd0);
        add(0, 0, 6'h00, 0, 6'h12, 0, 1, 0, 3'd0);
        add(0, 1, 6'h3A, 0, 6'h12, 0, 0, 0, 3'd0);  // DEFAULT
        add(0, 0, 6'h00, 0, 6'h12, 0, 0, 0, 3'd0);
        add(0, 0, 6'h00, 0, 6'h01, 0, 1, 0, 3'd0);
        add(0, 1, 6'h1A, 0, 6'h01, 0, 0, 0, 3'd0);  // bad check beat
        add(0, 1, 6'h24, 0, 6'h01, 0, 0, 0, 3'd0);
        add(0, 1, 6'h00, 0, 6'h01, 0, 0, 1, 3'd5);
        add(0, 0, 6'h00, 0, 6'h01, 0, 0, 0, 3'd5);
        add(0, 1, 6'h1A, 0, 6'h01, 0, 0, 0, 3'd0);  // collision during APPLY
        add(0, 1, 6'h24, 0, 6'h01, 0, 0, 0, 3'd0);
        add(0, 1, 6'h1B, 0, 6'h01, 0, 0, 0, 3'd0);
        add(0, 0, 6'h00, 0, 6'h01, 1, 0, 0, 3'd0);
        add(0, 1, 6'h2A, 1, 6'h01, 1, 0, 0, 3'd0);
        add(0, 0, 6'h00, 1, 6'h01, 1, 0, 0, 3'd0);
        add(0, 1, 6'h0A, 1, 6'h01, 1, 0, 1, 3'd7);
        add(0, 1, 6'h0A, 0, 6'h24, 0, 1, 0, 3'd7);
        add(0, 0, 6'h00, 0, 6'h24, 0, 0, 0, 3'd7);

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].q, vecs[i].d, vecs[i].b);
            chk($sformatf("vec%0d", i), vecs[i].act, vecs[i].pend, vecs[i].done,
                vecs[i].err, vecs[i].code);
        end

        // Timeout: busy held for the whole window.
        wr(6'h12);
        chk("tmo_wr", 6'h24, 1, 0, 0, 3'd0);
        step(0, 1, 6'h2A, 1);
        step(0, 0, 6'h00, 1);
        chk("tmo_entry", 6'h24, 1, 0, 0, 3'd0);
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 6'h00, 1);
            chk($sformatf("tmo_cyc%0d", i), 6'h24, 1, 0, (i == 16), (i == 16) ? 3'd6 : 3'd0);
        end
        step(0, 0, 6'h00, 0);
        chk("tmo_after", 6'h24, 1, 0, 0, 3'd6);

        // Busy releases on the 5th APPLY cycle.
        step(0, 1, 6'h2A, 1);
        step(0, 0, 6'h00, 1);
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 6'h00, (i < 5));
            if (i < 5) chk($sformatf("late_cyc%0d", i), 6'h24, 1, 0, 0, 3'd0);
            else       chk("late_apply", 6'h12, 0, 1, 0, 3'd0);
        end
        step(0, 0, 6'h00, 1);
        chk("late_after", 6'h12, 0, 0, 0, 3'd0);

        // Reset mid-APPLY, after a collision has set err_code.
        wr(6'h24);
        chk("rsta_wr", 6'h12, 1, 0, 0, 3'd0);
        step(0, 1, 6'h2A, 1);
        step(0, 0, 6'h00, 1);
        step(0, 1, 6'h0A, 1);
        chk("rsta_collide", 6'h12, 1, 0, 1, 3'd7);
        step(1, 0, 6'h00, 1);
        chk("rsta_reset", 6'h01, 0, 0, 0, 3'd0);
        step(0, 0, 6'h00, 0);
        chk("rsta_noapply", 6'h01, 0, 0, 0, 3'd0);

        // Reset mid-WRITE, then a normal frame.
        step(0, 1, 6'h1A, 0);
        step(0, 1, 6'h24, 0);
        step(1, 0, 6'h00, 0);
        chk("rstw_reset", 6'h01, 0, 0, 0, 3'd0);
        step(0, 0, 6'h00, 0);
        chk("rstw_idle", 6'h01, 0, 0, 0, 3'd0);
        wr(6'h12);
        chk("rstw_wr", 6'h01, 1, 0, 0, 3'd0);
        step(0, 1, 6'h2A, 0);
        step(0, 0, 6'h00, 0);
        step(0, 0, 6'h00, 0);
        chk("rstw_commit", 6'h12, 0, 1, 0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
